seq_pattern_detector: RTL and testbench

- Parametrised serial pattern detector: recognises a programmable LEN-bit sequence on a one-bit qualified input stream.
- Pulses a registered `match` output and keeps a saturating match count.
- Generalises the fixed two-input "A then B" recogniser to arbitrary pattern length, with overlapping and non-overlapping modes and input-valid gaps.
- Sits on the serial-input side of the datapath and feeds event counters and interrupt logic.

---
 rtl/seq_pattern_detector_pkg.sv | 15 +
 rtl/seq_pattern_detector_if.sv | 28 ++
 rtl/seq_pattern_detector_sat_counter.sv | 30 +++
 rtl/seq_pattern_detector.sv | 106 ++++++++++
 tb/tb_seq_pattern_detector.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/seq_pattern_detector_pkg.sv
// Shared types and limits for the serial pattern detector.
//   det_state_t : detector FSM state (FILL while history is short, ARMED once full)
//   LEN_MAX     : largest supported pattern length
//   CNT_W_MAX   : largest supported match-counter width
package seq_det_pkg;

    localparam int unsigned LEN_MAX   = 32;
    localparam int unsigned CNT_W_MAX = 32;

    typedef enum logic {
        FILL  = 1'b0,
        ARMED = 1'b1
    } det_state_t;

endpackage

// File: rtl/seq_pattern_detector_if.sv
// Control/stream/result bundle for seq_pattern_detector.
//   clear, pattern, overlap, in_valid, in_bit : driven by the stream source (master)
//   match, match_count, armed                 : driven by the detector (slave)
interface seq_pattern_detector_if #(
    parameter int unsigned LEN   = 4,
    parameter int unsigned CNT_W = 8
) ();

    logic             clear;
    logic [LEN-1:0]   pattern;
    logic             overlap;
    logic             in_valid;
    logic             in_bit;
    logic             match;
    logic [CNT_W-1:0] match_count;
    logic             armed;

    modport master (
        output clear, pattern, overlap, in_valid, in_bit,
        input  match, match_count, armed
    );

    modport slave (
        input  clear, pattern, overlap, in_valid, in_bit,
        output match, match_count, armed
    );

endinterface

// File: rtl/seq_pattern_detector_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear to zero (wins over inc)
//   inc        : increment request; ignored once the count is all-ones
//   q          : current count
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/seq_pattern_detector.sv
// Serial pattern detector: matches a latched LEN-bit pattern against a
// qualified one-bit stream, with overlapping or non-overlapping detection.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of seq_pattern_detector_if
//                (clear/pattern/overlap/in_valid/in_bit in; match/match_count/armed out)
module seq_pattern_detector
    import seq_det_pkg::*;
#(
    parameter int unsigned LEN   = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seq_pattern_detector_if.slave bus
);

    localparam int unsigned FILL_W = $clog2(LEN + 1);

    // Elaboration-time parameter range checks
    if ((LEN < 2) || (LEN > LEN_MAX)) begin : g_bad_len
        $error("seq_pattern_detector: LEN out of range");
    end
    if ((CNT_W < 1) || (CNT_W > CNT_W_MAX)) begin : g_bad_cnt_w
        $error("seq_pattern_detector: CNT_W out of range");
    end

    det_state_t        state_q, state_d;
    logic [LEN-1:0]    hist_q, hist_d;
    logic [LEN-1:0]    pat_q, pat_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              match_q, match_d;

    logic              accept_c;
    logic              hit_c;
    logic [LEN-1:0]    shifted_c;

    // clear drops any bit presented in the same cycle
    assign accept_c  = bus.in_valid & ~bus.clear;
    assign shifted_c = {hist_q[LEN-2:0], bus.in_bit};
    // In FILL a hit is only possible on the bit that completes the history
    assign hit_c     = accept_c && (shifted_c == pat_q) &&
                       ((fill_q >= FILL_W'(LEN - 1)) || (state_q == ARMED));

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            hist_q  <= '0;
            pat_q   <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            pat_q   <= pat_d;
            fill_q  <= fill_d;
            match_q <= match_d;
        end
    end

    // Next-state: flush on clear, otherwise shift/fill/compare on accepted bits
    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        pat_d   = pat_q;
        fill_d  = fill_q;
        match_d = 1'b0;

        if (bus.clear) begin
            pat_d   = bus.pattern;
            hist_d  = '0;
            fill_d  = '0;
            state_d = FILL;
        end else if (accept_c) begin
            hist_d = shifted_c;
            if (state_q == FILL) begin
                fill_d = fill_q + FILL_W'(1);
                if (fill_q == FILL_W'(LEN - 1)) begin
                    state_d = ARMED;
                end
            end
            if (hit_c) begin
                match_d = 1'b1;
                // Non-overlapping: matched bits must not seed the next match
                if (!bus.overlap) begin
                    state_d = FILL;
                    fill_d  = '0;
                end
            end
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bus.clear),
        .inc   (hit_c),
        .q     (bus.match_count)
    );

    assign bus.match = match_q;
    assign bus.armed = (state_q == ARMED);

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Scoreboard bench: two detectors (CNT_W=8 and CNT_W=2) share one stimulus
// stream; the driver queues hand-derived expectations, a monitor checks them.
module tb_seq_pattern_detector;

    localparam int unsigned LEN = 4;

    typedef struct {
        logic       m;
        logic       a;
        logic [7:0] ca;
        logic [1:0] cb;
        string      tag;
    } exp_t;

    logic clk;
    logic rst_n;

    exp_t q[$];
    int   n_vec;
    int   n_err;

    logic [7:0]     ca;
    logic [1:0]     cb;
    logic [LEN-1:0] pat_in;

    seq_pattern_detector_if #(.LEN(LEN), .CNT_W(8)) bus_a ();
    seq_pattern_detector_if #(.LEN(LEN), .CNT_W(2)) bus_b ();

    assign bus_b.clear    = bus_a.clear;
    assign bus_b.pattern  = bus_a.pattern;
    assign bus_b.overlap  = bus_a.overlap;
    assign bus_b.in_valid = bus_a.in_valid;
    assign bus_b.in_bit   = bus_a.in_bit;

    seq_pattern_detector #(.LEN(LEN), .CNT_W(8)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    seq_pattern_detector #(.LEN(LEN), .CNT_W(2)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one queued expectation per clock, checked mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                n_vec++;
                if ({bus_a.match, bus_a.armed, bus_a.match_count} !== {e.m, e.a, e.ca}) begin
                    n_err++;
                    $display("FAIL %s dutA: got match=%0b armed=%0b cnt=%0d, want match=%0b armed=%0b cnt=%0d",
                             e.tag, bus_a.match, bus_a.armed, bus_a.match_count, e.m, e.a, e.ca);
                end
                n_vec++;
                if ({bus_b.match, bus_b.armed, bus_b.match_count} !== {e.m, e.a, e.cb}) begin
                    n_err++;
                    $display("FAIL %s dutB: got match=%0b armed=%0b cnt=%0d, want match=%0b armed=%0b cnt=%0d",
                             e.tag, bus_b.match, bus_b.armed, bus_b.match_count, e.m, e.a, e.cb);
                end
            end
        end
    end

    // One clock of stimulus; expected count tracks hand-marked match pulses
    task automatic step(input logic clr, input logic [LEN-1:0] pat, input logic v,
                        input logic b, input logic em, input logic ea, input string tag);
        exp_t e;
        bus_a.clear    = clr;
        bus_a.pattern  = pat;
        bus_a.in_valid = v;
        bus_a.in_bit   = b;
        @(posedge clk);
        if (clr) begin
            ca = '0;
            cb = '0;
        end else if (em) begin
            if (ca != 8'hff) ca = ca + 8'd1;
            if (cb != 2'b11) cb = cb + 2'd1;
        end
        e.m = em; e.a = ea; e.ca = ca; e.cb = cb; e.tag = tag;
        q.push_back(e);
        #1;
    endtask

    // Stream string: '0'/'1' valid bit, '.' idle cycle
    task automatic run(input string s, input string m, input string a, input string tag);
        for (int i = 0; i < s.len(); i++) begin
            step(1'b0, pat_in, s[i] != ".", s[i] == "1", m[i] == "1", a[i] == "1",
                 $sformatf("%s[%0d]", tag, i));
        end
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 10; k++) begin
            if (q.size() == 0) break;
            @(negedge clk);
            #1;
        end
        if (q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s drain: got %0d pending, want 0", tag, q.size());
            q.delete();
        end
    endtask

    task automatic check_zero(input string tag);
        n_vec++;
        if ({bus_a.match, bus_a.armed, bus_a.match_count} !== 10'd0) begin
            n_err++;
            $display("FAIL %s dutA: got match=%0b armed=%0b cnt=%0d, want all 0",
                     tag, bus_a.match, bus_a.armed, bus_a.match_count);
        end
        n_vec++;
        if ({bus_b.match, bus_b.armed, bus_b.match_count} !== 4'd0) begin
            n_err++;
            $display("FAIL %s dutB: got match=%0b armed=%0b cnt=%0d, want all 0",
                     tag, bus_b.match, bus_b.armed, bus_b.match_count);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        ca = '0;
        cb = '0;
        pat_in = '0;
        rst_n = 1'b1;
        bus_a.clear    = 1'b0;
        bus_a.pattern  = '0;
        bus_a.overlap  = 1'b1;
        bus_a.in_valid = 1'b0;
        bus_a.in_bit   = 1'b0;
        #1 rst_n = 1'b0;
        #2 check_zero("reset");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Overlapping, continuous stream
        bus_a.overlap = 1'b1;
        pat_in = 4'b1011;
        step(1'b1, pat_in, 1'b0, 1'b0, 1'b0, 1'b0, "clr_ov");
        run("1011011", "0001001", "0001111", "ov");

        // Non-overlapping: completing bits are not reused
        bus_a.overlap = 1'b0;
        step(1'b1, pat_in, 1'b0, 1'b0, 1'b0, 1'b0, "clr_nov");
        run("10110110", "00010000", "00000001", "nov");

        // Overlapping with two idle cycles between bits
        bus_a.overlap = 1'b1;
        step(1'b1, pat_in, 1'b0, 1'b0, 1'b0, 1'b0, "clr_gap");
        run("1..0..1..1..0..1..1", "0000000001000000001", "0000000001111111111", "gap");

        // Counter saturation on the narrow instance
        pat_in = 4'b1111;
        step(1'b1, pat_in, 1'b0, 1'b0, 1'b0, 1'b0, "clr_sat");
        run("11111111", "00011111", "00011111", "sat");

        // Clear drops a simultaneous valid bit; later pattern edits are ignored
        step(1'b1, 4'b0110, 1'b1, 1'b1, 1'b0, 1'b0, "clr_drop");
        pat_in = 4'b1111;
        run("0110110", "0001001", "0001111", "clr_pat");

        // Async reset mid-stream, then detection against the reset pattern 0000
        pat_in = 4'b1011;
        step(1'b1, pat_in, 1'b0, 1'b0, 1'b0, 1'b0, "clr_rst");
        run("1011101", "0001000", "0001111", "pre_rst");
        drain("pre_rst");
        #2 rst_n = 1'b0;
        #1 check_zero("async_rst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        ca = '0;
        cb = '0;
        bus_a.overlap = 1'b0;
        run("000000", "000100", "000000", "post_rst");
        drain("end");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
